// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scrolling display slice.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_BLANK = 8'h20;

endpackage

// File: rtl/switch_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability filter and a
// one-cycle pulse on each rising edge of the filtered level.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Level,
    output logic o_Rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          level_d_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, then accept a new level only after it has held long enough
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            cnt_r     <= {CW{1'b0}};
        end else begin
            sync1_r   <= i_Switch;
            sync2_r   <= sync1_r;
            level_d_r <= level_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= {CW{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= {CW{1'b0}};
            end
        end
    end

    assign o_Level = level_r;
    assign o_Rise  = level_r & ~level_d_r;

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Scrolls a buffered ASCII message through a two-character window on the
// seven-segment pair; the debounced switch toggles run/pause.
module seg_scroll_ctrl
    import seg_pkg::*;
#(
    parameter int MSG_DEPTH       = 16,
    parameter int STEP_CYCLES     = 6250000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_L,
    input  logic                         i_Switch_1,
    input  logic                         i_Wr_En,
    input  logic [$clog2(MSG_DEPTH)-1:0] i_Wr_Addr,
    input  logic [7:0]                   i_Wr_Data,
    input  logic                         i_Len_Wr_En,
    input  logic [$clog2(MSG_DEPTH):0]   i_Len,
    output logic [7:0]                   o_Char_Left,
    output logic [7:0]                   o_Char_Right,
    output logic                         o_Running
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0] STEP_ONE  = SW'(1);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MSG_DEPTH);
    localparam logic [LW-1:0] LEN_ONE   = LW'(1);

    logic [7:0]    msg_buf_r [MSG_DEPTH];
    state_e        state_r, state_nxt_s;
    logic [LW-1:0] len_r, len_nxt_s, len_clamp_s;
    logic [AW-1:0] idx_r, idx_nxt_s, idx_wrap_s;
    logic [LW-1:0] idx_inc_s;
    logic [SW-1:0] step_cnt_r, step_cnt_nxt_s;
    logic [7:0]    char_left_r, char_right_r;
    logic          running_r;
    logic          sw_level_s, sw_rise_s, press_s;

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw1 (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Switch(i_Switch_1),
        .o_Level (sw_level_s),
        .o_Rise  (sw_rise_s)
    );

    assign press_s = sw_rise_s & sw_level_s;

    // Message buffer: writable in any state, deliberately not reset
    always_ff @(posedge i_Clk) begin
        if (i_Wr_En) begin
            msg_buf_r[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    // Next-state logic; a length write outranks both a step and a press
    always_comb begin
        idx_inc_s      = {1'b0, idx_r} + LEN_ONE;
        idx_wrap_s     = (idx_inc_s == len_r) ? {AW{1'b0}} : idx_inc_s[AW-1:0];
        len_clamp_s    = (i_Len > LEN_MAX) ? LEN_MAX : i_Len;
        state_nxt_s    = state_r;
        len_nxt_s      = len_r;
        idx_nxt_s      = idx_r;
        step_cnt_nxt_s = step_cnt_r;
        if (i_Len_Wr_En) begin
            len_nxt_s      = len_clamp_s;
            idx_nxt_s      = {AW{1'b0}};
            step_cnt_nxt_s = STEP_LAST;
            if (len_clamp_s == {LW{1'b0}}) begin
                state_nxt_s = ST_IDLE;
            end else if (state_r == ST_IDLE) begin
                state_nxt_s = ST_RUN;
            end else begin
                state_nxt_s = state_r;
            end
        end else begin
            if (state_r == ST_RUN) begin
                if (step_cnt_r == {SW{1'b0}}) begin
                    step_cnt_nxt_s = STEP_LAST;
                    idx_nxt_s      = idx_wrap_s;
                end else begin
                    step_cnt_nxt_s = step_cnt_r - STEP_ONE;
                end
            end else begin
                step_cnt_nxt_s = step_cnt_r;
            end
            if (press_s) begin
                case (state_r)
                    ST_RUN:   state_nxt_s = ST_PAUSE;
                    ST_PAUSE: state_nxt_s = ST_RUN;
                    default:  state_nxt_s = state_r;
                endcase
            end else begin
                state_nxt_s = state_r;
            end
        end
    end

    // Control state registers
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_r    <= ST_IDLE;
            len_r      <= {LW{1'b0}};
            idx_r      <= {AW{1'b0}};
            step_cnt_r <= STEP_LAST;
        end else begin
            state_r    <= state_nxt_s;
            len_r      <= len_nxt_s;
            idx_r      <= idx_nxt_s;
            step_cnt_r <= step_cnt_nxt_s;
        end
    end

    // Registered window; a one-character message shows a blank on the right
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            char_left_r  <= ASCII_BLANK;
            char_right_r <= ASCII_BLANK;
            running_r    <= 1'b0;
        end else begin
            running_r <= (state_r == ST_RUN);
            if (state_r == ST_IDLE) begin
                char_left_r  <= ASCII_BLANK;
                char_right_r <= ASCII_BLANK;
            end else begin
                char_left_r  <= msg_buf_r[idx_r];
                char_right_r <= (len_r == LEN_ONE) ? ASCII_BLANK : msg_buf_r[idx_wrap_s];
            end
        end
    end

    assign o_Char_Left  = char_left_r;
    assign o_Char_Right = char_right_r;
    assign o_Running    = running_r;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Directed bench for seg_scroll_ctrl with short step and debounce periods.
module tb_seg_scroll_ctrl;

    localparam int MSG_DEPTH       = 4;
    localparam int STEP_CYCLES     = 4;
    localparam int DEBOUNCE_CYCLES = 3;

    localparam logic [7:0] SP   = 8'h20;
    localparam logic [7:0] CH_A = 8'h41;
    localparam logic [7:0] CH_B = 8'h42;
    localparam logic [7:0] CH_C = 8'h43;
    localparam logic [7:0] CH_D = 8'h44;
    localparam logic [7:0] CH_H = 8'h48;
    localparam logic [7:0] CH_Z = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       sw;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       len_wr_en;
    logic [2:0] len;
    logic [7:0] char_l;
    logic [7:0] char_r;
    logic       running;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg_scroll_ctrl #(
        .MSG_DEPTH      (MSG_DEPTH),
        .STEP_CYCLES    (STEP_CYCLES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_l),
        .i_Switch_1  (sw),
        .i_Wr_En     (wr_en),
        .i_Wr_Addr   (wr_addr),
        .i_Wr_Data   (wr_data),
        .i_Len_Wr_En (len_wr_en),
        .i_Len       (len),
        .o_Char_Left (char_l),
        .o_Char_Right(char_r),
        .o_Running   (running)
    );

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_l = 1'b0; sw = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
        len_wr_en = 1'b0; len = 3'd0;
        tick(); tick();
        n_cmp++;
        if ({char_l, char_r} !== {SP, SP}) begin
            n_bad++; $display("FAIL reset_chars: got %h expected %h", {char_l, char_r}, {SP, SP});
        end
        n_cmp++;
        if (running !== 1'b0) begin
            n_bad++; $display("FAIL reset_running: got %b expected 0", running);
        end
        rst_l = 1'b1;
    endtask

    task automatic test_load();
        logic [7:0] msg [3];
        msg = '{CH_A, CH_B, CH_C};
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = msg[i];
            tick();
        end
        wr_en = 1'b0;
        tick();
        n_cmp++;
        if ({char_l, char_r, running} !== {SP, SP, 1'b0}) begin
            n_bad++; $display("FAIL idle_before_len: got %h/%b expected %h/0", {char_l, char_r}, running, {SP, SP});
        end
        len_wr_en = 1'b1; len = 3'd3;
        tick();
        len_wr_en = 1'b0;
        tick();
        n_cmp++;
        if ({char_l, char_r, running} !== {CH_A, CH_B, 1'b1}) begin
            n_bad++; $display("FAIL load_window: got %h/%b expected %h/1", {char_l, char_r}, running, {CH_A, CH_B});
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_w [4];
        exp_w = '{{CH_A, CH_B}, {CH_B, CH_C}, {CH_C, CH_A}, {CH_A, CH_B}};
        for (int j = 0; j < 16; j++) begin
            n_cmp++;
            if ({char_l, char_r} !== exp_w[j / 4]) begin
                n_bad++; $display("FAIL wrap_window[%0d]: got %h expected %h", j, {char_l, char_r}, exp_w[j / 4]);
            end
            tick();
        end
    endtask

    task automatic test_debounce();
        sw = 1'b1; tick();
        sw = 1'b0; tick();
        sw = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++;
            if (running !== 1'b1) begin
                n_bad++; $display("FAIL bounce_early_toggle[%0d]: got %b expected 1", k, running);
            end
        end
        tick();
        n_cmp++;
        if (running !== 1'b0) begin
            n_bad++; $display("FAIL pause_toggle: got %b expected 0", running);
        end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if ({char_l, char_r, running} !== {CH_A, CH_B, 1'b0}) begin
                n_bad++; $display("FAIL frozen[%0d]: got %h/%b expected %h/0", k, {char_l, char_r}, running, {CH_A, CH_B});
            end
            tick();
        end
        sw = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        n_cmp++;
        if (running !== 1'b0) begin
            n_bad++; $display("FAIL release_action: got %b expected 0", running);
        end
        sw = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        n_cmp++;
        if (running !== 1'b0) begin
            n_bad++; $display("FAIL resume_early: got %b expected 0", running);
        end
        tick();
        n_cmp++;
        if (running !== 1'b1) begin
            n_bad++; $display("FAIL resume_toggle: got %b expected 1", running);
        end
        tick(); tick();
        n_cmp++;
        if ({char_l, char_r} !== {CH_A, CH_B}) begin
            n_bad++; $display("FAIL resume_hold: got %h expected %h", {char_l, char_r}, {CH_A, CH_B});
        end
        tick();
        n_cmp++;
        if ({char_l, char_r} !== {CH_B, CH_C}) begin
            n_bad++; $display("FAIL resume_remaining: got %h expected %h", {char_l, char_r}, {CH_B, CH_C});
        end
    endtask

    task automatic test_single_clamp();
        logic [15:0] exp_w [4];
        exp_w = '{{CH_H, CH_B}, {CH_B, CH_C}, {CH_C, CH_D}, {CH_D, CH_H}};
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = CH_H;
        tick();
        wr_en = 1'b0; len_wr_en = 1'b1; len = 3'd1;
        tick();
        len_wr_en = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if ({char_l, char_r, running} !== {CH_H, SP, 1'b1}) begin
                n_bad++; $display("FAIL single_char[%0d]: got %h/%b expected %h/1", k, {char_l, char_r}, running, {CH_H, SP});
            end
            tick();
        end
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = CH_D;
        tick();
        wr_en = 1'b0; len_wr_en = 1'b1; len = 3'd7;
        tick();
        len_wr_en = 1'b0;
        tick();
        for (int j = 0; j < 16; j++) begin
            n_cmp++;
            if ({char_l, char_r} !== exp_w[j / 4]) begin
                n_bad++; $display("FAIL clamp_window[%0d]: got %h expected %h", j, {char_l, char_r}, exp_w[j / 4]);
            end
            tick();
        end
    endtask

    task automatic test_collisions();
        len_wr_en = 1'b1; len = 3'd4;
        tick();
        len_wr_en = 1'b0;
        tick(); tick(); tick();
        len_wr_en = 1'b1; len = 3'd4;
        tick();
        len_wr_en = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({char_l, char_r} !== {CH_H, CH_B}) begin
                n_bad++; $display("FAIL len_vs_step[%0d]: got %h expected %h", k, {char_l, char_r}, {CH_H, CH_B});
            end
            tick();
        end
        n_cmp++;
        if ({char_l, char_r} !== {CH_B, CH_C}) begin
            n_bad++; $display("FAIL len_vs_step_reload: got %h expected %h", {char_l, char_r}, {CH_B, CH_C});
        end
        len_wr_en = 1'b1; len = 3'd0;
        tick();
        len_wr_en = 1'b0;
        tick();
        n_cmp++;
        if ({char_l, char_r, running} !== {SP, SP, 1'b0}) begin
            n_bad++; $display("FAIL len_zero_idle: got %h/%b expected %h/0", {char_l, char_r}, running, {SP, SP});
        end
        sw = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        sw = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        n_cmp++;
        if ({char_l, char_r, running} !== {SP, SP, 1'b0}) begin
            n_bad++; $display("FAIL idle_press: got %h/%b expected %h/0", {char_l, char_r}, running, {SP, SP});
        end
    endtask

    task automatic test_edit_reset();
        sw = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        len_wr_en = 1'b1; len = 3'd3;
        tick();
        len_wr_en = 1'b0;
        tick();
        n_cmp++;
        if ({char_l, char_r, running} !== {CH_H, CH_B, 1'b1}) begin
            n_bad++; $display("FAIL edit_before: got %h/%b expected %h/1", {char_l, char_r}, running, {CH_H, CH_B});
        end
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = CH_Z;
        tick();
        wr_en = 1'b0;
        tick();
        n_cmp++;
        if ({char_l, char_r} !== {CH_Z, CH_B}) begin
            n_bad++; $display("FAIL live_edit: got %h expected %h", {char_l, char_r}, {CH_Z, CH_B});
        end
        tick();
        rst_l = 1'b0;
        tick();
        n_cmp++;
        if ({char_l, char_r, running} !== {SP, SP, 1'b0}) begin
            n_bad++; $display("FAIL mid_reset: got %h/%b expected %h/0", {char_l, char_r}, running, {SP, SP});
        end
        rst_l = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({char_l, char_r, running} !== {SP, SP, 1'b0}) begin
            n_bad++; $display("FAIL after_reset_idle: got %h/%b expected %h/0", {char_l, char_r}, running, {SP, SP});
        end
        len_wr_en = 1'b1; len = 3'd3;
        tick();
        len_wr_en = 1'b0;
        tick();
        n_cmp++;
        if ({char_l, char_r, running} !== {CH_Z, CH_B, 1'b1}) begin
            n_bad++; $display("FAIL buffer_kept: got %h/%b expected %h/1", {char_l, char_r}, running, {CH_Z, CH_B});
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_wrap();
        test_debounce();
        test_single_clamp();
        test_collisions();
        test_edit_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
